pwm_multi_ramp: RTL and testbench

Multi-channel PWM generator with glitch-free duty updates and a built-in per-channel ramp engine (sawtooth or triangle "breathing"), replacing ad-hoc top-level duty-stepping logic. One shared period counter drives CHANNELS comparators. The block sits between the board top level and the LED/output pins. Configuration comes from a simple single-cycle write port.

---
 rtl/pwm_multi_ramp_if.sv | 16 +
 rtl/pwm_multi_ramp.sv | 123 ++++++++++++
 tb/tb_pwm_multi_ramp.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_ramp_if.sv
// Configuration write port for pwm_multi_ramp: one single-cycle write per strobe.
interface pwm_multi_ramp_if #(
    parameter int CHANNELS = 6,
    parameter int WIDTH    = 8
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [WIDTH-1:0] cfg_duty;
    logic [WIDTH-1:0] cfg_step;

    modport master (output cfg_we, output cfg_ch, output cfg_mode, output cfg_duty, output cfg_step);
    modport slave  (input  cfg_we, input  cfg_ch, input  cfg_mode, input  cfg_duty, input  cfg_step);
endinterface

// File: rtl/pwm_multi_ramp.sv
// Multi-channel PWM with shadowed duty registers and a per-channel sawtooth/triangle ramp engine.
// One shared period counter feeds every comparator; duty changes reach the pins only at period wrap.
module pwm_multi_ramp #(
    parameter int CHANNELS   = 6,
    parameter int WIDTH      = 8,
    parameter int RAMP_DIV   = 27000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    pwm_multi_ramp_if.slave     cfg,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_end,
    output logic                ramp_tick
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [WIDTH-1:0]    P        = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]    CNT_LAST = P - WIDTH'(1);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic                OFF_LVL  = (ACTIVE_LOW != 0);
    localparam logic [CHANNELS-1:0] OFF_MASK = {CHANNELS{OFF_LVL}};

    localparam logic [1:0] MODE_SAW = 2'b01;
    localparam logic [1:0] MODE_TRI = 2'b10;
    localparam logic [1:0] MODE_OFF = 2'b11;

    logic [WIDTH-1:0]    cnt_p0;
    logic [PRE_W-1:0]    pre_p0;
    logic [WIDTH-1:0]    pending [CHANNELS];
    logic [WIDTH-1:0]    active  [CHANNELS];
    logic [1:0]          mode    [CHANNELS];
    logic [WIDTH-1:0]    step    [CHANNELS];
    logic [CHANNELS-1:0] dir_dn;
    logic [CHANNELS-1:0] raw_p0;
    logic [CHANNELS-1:0] pwm_p1;
    logic                period_end_p1;
    logic                ramp_tick_p1;
    logic                wrap_p0;
    logic                pre_wrap_p0;

    // Next {dir_dn, pending} for one channel on a ramp tick.
    function automatic logic [WIDTH:0] ramp_next(input logic [1:0]       md,
                                                 input logic             dn,
                                                 input logic [WIDTH-1:0] pend,
                                                 input logic [WIDTH-1:0] stp);
        logic [WIDTH:0] sum;
        logic [WIDTH:0] res;
        sum = {1'b0, pend} + {1'b0, stp};
        res = {dn, pend};
        if (stp != '0) begin
            if (md == MODE_SAW) begin
                res = {dn, sum[WIDTH-1:0]};
            end else if (md == MODE_TRI) begin
                if (!dn) begin
                    res = (sum >= {1'b0, P}) ? {1'b1, P} : {1'b0, sum[WIDTH-1:0]};
                end else begin
                    res = (pend <= stp) ? {1'b0, {WIDTH{1'b0}}} : {1'b1, pend - stp};
                end
            end
        end
        return res;
    endfunction

    assign wrap_p0     = en && (cnt_p0 == CNT_LAST);
    assign pre_wrap_p0 = en && (pre_p0 == PRE_LAST);

    always_comb begin
        raw_p0 = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw_p0[i] = (cnt_p0 < active[i]) && (mode[i] != MODE_OFF);
        end
    end

    // ---- stage p0 -> p1: counters, compare register, shadow load, config/ramp ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p0        <= '0;
            pre_p0        <= '0;
            pwm_p1        <= OFF_MASK;
            period_end_p1 <= 1'b0;
            ramp_tick_p1  <= 1'b0;
            dir_dn        <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
                mode[i]    <= '0;
                step[i]    <= '0;
            end
        end else begin
            if (en) begin
                cnt_p0        <= wrap_p0 ? '0 : cnt_p0 + WIDTH'(1);
                pre_p0        <= pre_wrap_p0 ? '0 : pre_p0 + PRE_W'(1);
                pwm_p1        <= raw_p0 ^ OFF_MASK;
                period_end_p1 <= wrap_p0;
                ramp_tick_p1  <= pre_wrap_p0;
            end else begin
                cnt_p0        <= '0;
                pwm_p1        <= OFF_MASK;
                period_end_p1 <= 1'b0;
                ramp_tick_p1  <= 1'b0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wrap_p0) active[i] <= pending[i];
                // A write on a tick cycle wins over the ramp for that channel only.
                if (cfg.cfg_we && (cfg.cfg_ch == CH_W'(i))) begin
                    pending[i] <= cfg.cfg_duty;
                    mode[i]    <= cfg.cfg_mode;
                    step[i]    <= cfg.cfg_step;
                    dir_dn[i]  <= 1'b0;
                end else if (ramp_tick_p1) begin
                    {dir_dn[i], pending[i]} <= ramp_next(mode[i], dir_dn[i], pending[i], step[i]);
                end
            end
        end
    end

    assign pwm_out    = pwm_p1;
    assign period_end = period_end_p1;
    assign ramp_tick  = ramp_tick_p1;
endmodule

// File: tb/tb_pwm_multi_ramp.sv
// Directed bench for pwm_multi_ramp: 6 channels, 8-bit, ramp tick every 4 clocks, active-low pins.
module tb_pwm_multi_ramp;
    logic       clk;
    logic       rst;
    logic       en;
    logic [5:0] pwm_out;
    logic       period_end;
    logic       ramp_tick;

    int n_chk  = 0;
    int n_fail = 0;
    int mcnt   = 0;
    int mpre   = 0;
    int pe_err = 0;
    int rt_err = 0;

    pwm_multi_ramp_if #(.CHANNELS(6), .WIDTH(8)) cfg_bus ();

    pwm_multi_ramp #(.CHANNELS(6), .WIDTH(8), .RAMP_DIV(4), .ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg        (cfg_bus),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .ramp_tick  (ramp_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: model the period counter and prescaler, compare the pulse outputs.
    task automatic adv();
        logic pe_e;
        logic rt_e;
        @(posedge clk);
        pe_e = en && (mcnt == 254);
        rt_e = en && (mpre == 3);
        if (en) begin
            mcnt = (mcnt == 254) ? 0 : mcnt + 1;
            mpre = (mpre + 1) % 4;
        end else begin
            mcnt = 0;
        end
        @(negedge clk);
        if (period_end !== pe_e) pe_err++;
        if (ramp_tick !== rt_e) rt_err++;
    endtask

    task automatic wr(input int ch, input int md, input int duty, input int stp);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_ch   = 3'(ch);
        cfg_bus.cfg_mode = 2'(md);
        cfg_bus.cfg_duty = 8'(duty);
        cfg_bus.cfg_step = 8'(stp);
        adv();
        cfg_bus.cfg_we   = 1'b0;
    endtask

    task automatic goto_cnt(input int target);
        int n = 0;
        while (mcnt != target && n < 300) begin
            adv();
            n++;
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        while (ramp_tick !== 1'b1 && n < 8) begin
            adv();
            n++;
        end
        chk("ramp_tick_seen", ramp_tick, 1);
    endtask

    // Sample one full period starting from cnt = 0.
    task automatic measure(input int ch, output int lows, output int last_low, output logic [5:0] mask);
        lows     = 0;
        last_low = -1;
        mask     = '0;
        for (int k = 0; k < 255; k++) begin
            adv();
            mask = mask | ~pwm_out;
            if (pwm_out[ch] == 1'b0) begin
                lows++;
                last_low = k;
            end
        end
    endtask

    initial begin
        int         lows;
        int         last_low;
        int         pulses;
        int         first_pe;
        int         bad;
        int         s0;
        logic [5:0] mask;
        int         saw_exp [3] = '{4, 14, 24};
        int         tri_exp [7] = '{100, 200, 255, 155, 55, 0, 100};
        int         tri_dir [7] = '{0, 0, 1, 1, 1, 0, 0};

        rst = 1'b0;
        en  = 1'b1;
        cfg_bus.cfg_we   = 1'b0;
        cfg_bus.cfg_ch   = '0;
        cfg_bus.cfg_mode = '0;
        cfg_bus.cfg_duty = '0;
        cfg_bus.cfg_step = '0;
        repeat (3) @(negedge clk);
        chk("reset_pwm", pwm_out, 6'h3F);
        chk("reset_period_end", period_end, 0);
        chk("reset_ramp_tick", ramp_tick, 0);
        chk("reset_cnt", dut.cnt_p0, 0);
        rst = 1'b1;

        // Idle: three periods, all outputs inactive
        pulses = 0; first_pe = -1; bad = 0;
        for (int k = 1; k <= 765; k++) begin
            adv();
            if (pwm_out != 6'h3F) bad++;
            if (period_end) begin
                pulses++;
                if (first_pe < 0) first_pe = k;
            end
        end
        chk("idle_pwm_bad", bad, 0);
        chk("idle_pulses", pulses, 3);
        chk("idle_first_pe", first_pe, 255);

        // Static duty written mid-period stays invisible until the wrap
        goto_cnt(100);
        wr(2, 0, 64, 0);
        lows = 0;
        while (mcnt != 0) begin
            adv();
            if (pwm_out[2] == 1'b0) lows++;
        end
        chk("static_pre_wrap_lows", lows, 0);
        measure(2, lows, last_low, mask);
        chk("duty64_lows", lows, 64);
        chk("duty64_last_low", last_low, 63);
        chk("duty64_others", mask & 6'b111011, 0);
        wr(2, 0, 255, 0);
        goto_cnt(0);
        measure(2, lows, last_low, mask);
        chk("duty255_lows", lows, 255);
        wr(2, 0, 0, 0);
        goto_cnt(0);
        measure(2, lows, last_low, mask);
        chk("duty0_lows", lows, 0);

        // Sawtooth wraps modulo 256
        wait_tick();
        adv();
        wr(0, 1, 250, 10);
        chk("saw_start", dut.pending[0], 250);
        for (int t = 0; t < 3; t++) begin
            wait_tick();
            adv();
            chk("saw_pending", dut.pending[0], saw_exp[t]);
        end

        // Triangle bounces between 0 and P
        wr(1, 2, 0, 100);
        for (int t = 0; t < 7; t++) begin
            wait_tick();
            adv();
            chk("tri_pending", dut.pending[1], tri_exp[t]);
            chk("tri_dir", dut.dir_dn[1], tri_dir[t]);
        end

        // Write on a tick cycle wins; other channels still ramp
        wait_tick();
        s0 = dut.pending[0];
        wr(1, 2, 7, 100);
        chk("collide_pending", dut.pending[1], 7);
        chk("collide_dir", dut.dir_dn[1], 0);
        chk("collide_other_ramp", dut.pending[0], (s0 + 10) % 256);

        // Out-of-range channel is ignored
        wr(6, 2, 99, 50);
        chk("ignore_ch4", dut.pending[4], 0);
        chk("ignore_ch5", dut.pending[5], 0);
        chk("ignore_mode5", dut.mode[5], 0);

        // Forced-off mode
        wr(3, 3, 128, 0);
        goto_cnt(0);
        chk("off_active_loaded", dut.active[3], 128);
        measure(3, lows, last_low, mask);
        chk("off_lows", lows, 0);

        // Enable drop mid-period
        wr(2, 0, 200, 0);
        goto_cnt(0);
        goto_cnt(100);
        chk("en_pre_on", pwm_out[2], 0);
        en = 1'b0;
        adv();
        chk("en_off_pwm", pwm_out, 6'h3F);
        chk("en_off_cnt", dut.cnt_p0, 0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            adv();
            if (pwm_out != 6'h3F || period_end || ramp_tick) bad++;
        end
        wr(4, 0, 50, 0);
        chk("en_off_hold_bad", bad, 0);
        chk("en_off_write", dut.pending[4], 50);
        chk("en_off_keep_pending", dut.pending[2], 200);
        chk("en_off_keep_active", dut.active[2], 200);
        en = 1'b1;
        measure(2, lows, last_low, mask);
        chk("reen_lows", lows, 200);
        chk("reen_last_low", last_low, 199);
        chk("reen_ch4_not_loaded", mask[4], 0);

        // Asynchronous reset mid-period
        goto_cnt(100);
        chk("rst_pre_on", pwm_out[2], 0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_pwm", pwm_out, 6'h3F);
        chk("rst_period_end", period_end, 0);
        chk("rst_pending", dut.pending[2], 0);
        chk("rst_active", dut.active[2], 0);
        chk("rst_mode", dut.mode[0], 0);
        chk("rst_cnt", dut.cnt_p0, 0);
        repeat (3) @(negedge clk);
        mcnt = 0;
        mpre = 0;
        rst  = 1'b1;
        measure(2, lows, last_low, mask);
        chk("post_rst_mask", mask, 0);

        chk("period_end_align", pe_err, 0);
        chk("ramp_tick_align", rt_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
